// File: rtl/mem_rd_arb_pkg.sv
// Shared types for the masked memory read-request arbiter.
package mem_rd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ_OUT  = 2'd1,
    RESP_OUT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index at or above ptr_i, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [ID_W-1:0]    winner_o,
  output logic               any_valid_o
);

  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    winner_o = '0;
    idx      = '0;
    found    = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(ptr_i) + k) % NUM_REQ);
      if (!found && elig_i[idx]) begin
        winner_o = idx;
        found    = 1'b1;
      end
    end
    any_valid_o = found;
  end

endmodule

// File: rtl/mem_rd_req_arb.sv
// Round-robin arbiter granting one requester at a time a single request/response
// transaction on a shared memory read pipe.
module mem_rd_req_arb
  import mem_rd_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int REQ_W   = 512,
  parameter  int RESP_W  = 512,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_val,
  input  logic [NUM_REQ-1:0][REQ_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_rdy,
  input  logic [NUM_REQ-1:0]             req_en_mask,
  output logic                           arb_pipe_req_val,
  output logic [REQ_W-1:0]               arb_pipe_req_data,
  input  logic                           pipe_arb_req_rdy,
  input  logic                           pipe_arb_resp_val,
  input  logic [RESP_W-1:0]              pipe_arb_resp_data,
  input  logic                           pipe_arb_resp_last,
  output logic                           arb_pipe_resp_rdy,
  output logic [NUM_REQ-1:0]             resp_val,
  output logic [RESP_W-1:0]              resp_data,
  output logic                           resp_last,
  input  logic [NUM_REQ-1:0]             resp_rdy,
  output logic                           arb_busy,
  output logic [ID_W-1:0]                arb_grant_id,
  output arb_state_e                     dbg_state
);

  // Handshakes: a transfer happens in any cycle where valid and ready are both high;
  // a valid, once raised, holds with stable data until that transfer.

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] winner;
  logic            any_valid;

  // The enable mask only matters here, so it is only ever sampled while IDLE.
  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr_pick (
    .elig_i      (req_val & req_en_mask),
    .ptr_i       (rr_ptr_q),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    rr_ptr_d          = rr_ptr_q;
    req_rdy           = '0;
    resp_val          = '0;
    arb_pipe_req_val  = 1'b0;
    arb_pipe_req_data = '0;
    arb_pipe_resp_rdy = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_d = winner;
          state_d = REQ_OUT;
        end
      end
      REQ_OUT: begin
        arb_pipe_req_val  = req_val[grant_q];
        arb_pipe_req_data = req_data[grant_q];
        req_rdy[grant_q]  = pipe_arb_req_rdy;
        if (req_val[grant_q] && pipe_arb_req_rdy) state_d = RESP_OUT;
      end
      RESP_OUT: begin
        resp_val[grant_q] = pipe_arb_resp_val;
        arb_pipe_resp_rdy = resp_rdy[grant_q];
        if (pipe_arb_resp_val && resp_rdy[grant_q] && pipe_arb_resp_last) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_data    = pipe_arb_resp_data;
  assign resp_last    = pipe_arb_resp_last;
  assign arb_busy     = (state_q != IDLE);
  assign arb_grant_id = grant_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_rd_req_arb.sv
// Directed and randomized transactions on the read-request arbiter, checked
// against a round-robin reference model and a response-flit scoreboard.
module tb_mem_rd_req_arb;
  import mem_rd_arb_pkg::*;

  localparam int N  = 4;
  localparam int RW = 32;
  localparam int PW = 32;
  localparam int IW = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [N-1:0]          req_val;
  logic [N-1:0][RW-1:0]  req_data;
  logic [N-1:0]          req_rdy;
  logic [N-1:0]          req_en_mask;
  logic                  arb_pipe_req_val;
  logic [RW-1:0]         arb_pipe_req_data;
  logic                  pipe_arb_req_rdy;
  logic                  pipe_arb_resp_val;
  logic [PW-1:0]         pipe_arb_resp_data;
  logic                  pipe_arb_resp_last;
  logic                  arb_pipe_resp_rdy;
  logic [N-1:0]          resp_val;
  logic [PW-1:0]         resp_data;
  logic                  resp_last;
  logic [N-1:0]          resp_rdy;
  logic                  arb_busy;
  logic [IW-1:0]         arb_grant_id;
  arb_state_e            dbg_state;

  int n_cmp = 0;
  int n_mis = 0;
  int m_ptr = 0;
  logic [PW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_rd_req_arb #(.NUM_REQ(N), .REQ_W(RW), .RESP_W(PW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_val            (req_val),
    .req_data           (req_data),
    .req_rdy            (req_rdy),
    .req_en_mask        (req_en_mask),
    .arb_pipe_req_val   (arb_pipe_req_val),
    .arb_pipe_req_data  (arb_pipe_req_data),
    .pipe_arb_req_rdy   (pipe_arb_req_rdy),
    .pipe_arb_resp_val  (pipe_arb_resp_val),
    .pipe_arb_resp_data (pipe_arb_resp_data),
    .pipe_arb_resp_last (pipe_arb_resp_last),
    .arb_pipe_resp_rdy  (arb_pipe_resp_rdy),
    .resp_val           (resp_val),
    .resp_data          (resp_data),
    .resp_last          (resp_last),
    .resp_rdy           (resp_rdy),
    .arb_busy           (arb_busy),
    .arb_grant_id       (arb_grant_id),
    .dbg_state          (dbg_state)
  );

  // A granted requester must keep its valid up until the request is accepted.
  always @(posedge clk) begin
    if (rst_n && dbg_state == REQ_OUT) begin
      assert (req_val[arb_grant_id]) else begin
        n_mis++;
        $error("FAIL req_val_drop observed=0 expected=1 grant=%0d", arb_grant_id);
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: scan requesters starting at the pointer, wrapping.
  function automatic int model_pick(input logic [N-1:0] elig, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (elig[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic idle_outputs(input string tag);
    chk({tag, "/state"},    64'(dbg_state), 64'(IDLE));
    chk({tag, "/busy"},     64'(arb_busy), 64'(0));
    chk({tag, "/preq_val"}, 64'(arb_pipe_req_val), 64'(0));
    chk({tag, "/req_rdy"},  64'(req_rdy), 64'(0));
    chk({tag, "/resp_val"}, 64'(resp_val), 64'(0));
    chk({tag, "/presp_rdy"}, 64'(arb_pipe_resp_rdy), 64'(0));
  endtask

  // ---------------- driver tasks ----------------
  // Entered just after a falling edge with the DUT idle and requests applied.
  task automatic grant_phase(input int g, input int stall, input string tag);
    chk({tag, "/pre_busy"}, 64'(arb_busy), 64'(0));
    chk({tag, "/pre_preq"}, 64'(arb_pipe_req_val), 64'(0));
    pipe_arb_req_rdy = 1'b0;
    @(negedge clk); #1;
    chk({tag, "/grant"},    64'(arb_grant_id), 64'(g));
    chk({tag, "/busy"},     64'(arb_busy), 64'(1));
    chk({tag, "/preq_val"}, 64'(arb_pipe_req_val), 64'(1));
    chk({tag, "/preq_dat"}, 64'(arb_pipe_req_data), 64'(req_data[g]));
    chk({tag, "/rdy_lo"},   64'(req_rdy), 64'(0));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk); #1;
      chk({tag, "/stall_st"},  64'(dbg_state), 64'(REQ_OUT));
      chk({tag, "/stall_rdy"}, 64'(req_rdy), 64'(0));
      chk({tag, "/stall_dat"}, 64'(arb_pipe_req_data), 64'(req_data[g]));
    end
    pipe_arb_req_rdy = 1'b1; #1;
    chk({tag, "/req_rdy"}, 64'(req_rdy), 64'(1) << g);
    @(negedge clk);
    pipe_arb_req_rdy = 1'b0; #1;
    chk({tag, "/resp_st"}, 64'(dbg_state), 64'(RESP_OUT));
    chk({tag, "/preq_off"}, 64'(arb_pipe_req_val), 64'(0));
  endtask

  // rdy_mode: 0 always ready, 1 toggling 1,0,1,..., 2 random with valid bubbles.
  task automatic resp_phase(input int g, input int nflits, input int rdy_mode,
                            input bit clr_mask0, input string tag);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    bit have = 0;
    logic [PW-1:0] flit = '0;
    logic [N-1:0]  r;
    while (got < nflits && cyc < 200) begin
      if (!have && (rdy_mode != 2 || $urandom_range(0, 3) != 0)) begin
        flit = $urandom;
        have = 1;
        sent++;
        exp_q.push_back(flit);
      end
      pipe_arb_resp_val  = have;
      pipe_arb_resp_data = have ? flit : '0;
      pipe_arb_resp_last = have && (sent == nflits);
      r = N'($urandom);
      case (rdy_mode)
        0:       r[g] = 1'b1;
        1:       r[g] = (cyc % 2 == 0);
        default: r[g] = 1'($urandom_range(0, 1));
      endcase
      resp_rdy = r;
      if (clr_mask0 && cyc == 1) req_en_mask[0] = 1'b0;
      #1;
      chk({tag, "/r_busy"},   64'(arb_busy), 64'(1));
      chk({tag, "/resp_val"}, 64'(resp_val), have ? (64'(1) << g) : 64'(0));
      chk({tag, "/presp_rdy"}, 64'(arb_pipe_resp_rdy), 64'(r[g]));
      chk({tag, "/resp_last"}, 64'(resp_last), 64'(pipe_arb_resp_last));
      if (have && r[g]) begin
        got++;
        chk({tag, "/sb_flit"}, 64'(resp_data), 64'(exp_q.pop_front()));
        have = 0;
      end
      @(negedge clk);
      cyc++;
    end
    pipe_arb_resp_val  = 1'b0;
    pipe_arb_resp_data = '0;
    pipe_arb_resp_last = 1'b0;
    resp_rdy           = '0;
    chk({tag, "/flits_done"}, 64'(got), 64'(nflits));
    chk({tag, "/sb_empty"},   64'(exp_q.size()), 64'(0));
    exp_q.delete();
    #1;
    idle_outputs({tag, "/end"});
    m_ptr = (g + 1) % N;
  endtask

  task automatic txn(input string tag, input int nfl, input int stall, input int mode,
                     input bit clr);
    int g;
    g = model_pick(req_val & req_en_mask, m_ptr);
    if (g >= 0) begin
      grant_phase(g, stall, tag);
      resp_phase(g, nfl, mode, clr, tag);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    req_val = '0; req_en_mask = '0; pipe_arb_req_rdy = 0;
    pipe_arb_resp_val = 0; pipe_arb_resp_data = '0; pipe_arb_resp_last = 0;
    resp_rdy = '0;
    for (int i = 0; i < N; i++) req_data[i] = $urandom;
    #1;
    idle_outputs("reset");
    chk("reset/grant", 64'(arb_grant_id), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1; #1;

    // Sparse requesters from pointer 0, then pointer advances past the winner.
    req_en_mask = 4'b1111; req_val = 4'b1010;
    txn("rr_a", 1, 0, 0, 0);
    txn("rr_b", 2, 0, 0, 0);

    // Only a masked-off requester is valid: no grant.
    req_en_mask = 4'b0111; req_val = 4'b1000;
    repeat (3) begin @(negedge clk); #1; idle_outputs("masked"); end

    // All requesting continuously with 3-flit responses.
    req_en_mask = 4'b1111; req_val = 4'b1111;
    for (int t = 0; t < 5; t++) txn("cont", 3, 0, 0, 0);

    txn("stall5", 2, 5, 0, 0);
    txn("toggle", 3, 0, 1, 0);

    for (int t = 0; t < 24; t++) begin
      req_val     = N'($urandom_range(0, 15));
      req_en_mask = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) req_data[i] = $urandom;
      if ((req_val & req_en_mask) == '0) begin
        @(negedge clk); #1;
        idle_outputs("rand_idle");
      end else begin
        txn("rand", $urandom_range(1, 4), $urandom_range(0, 3), 2, 0);
      end
    end

    // Mask for the granted requester drops mid-response; the transaction completes.
    req_val = 4'b0001; req_en_mask = 4'b1111;
    txn("mask_mid", 3, 0, 0, 1);
    @(negedge clk); #1;
    idle_outputs("mask_after");

    // Reset in the middle of a response drops it and clears the pointer.
    req_en_mask = 4'b1111; req_val = 4'b0100;
    grant_phase(model_pick(req_val & req_en_mask, m_ptr), 0, "rst_mid");
    pipe_arb_resp_val = 1'b1; pipe_arb_resp_data = $urandom;
    pipe_arb_resp_last = 1'b0; resp_rdy = 4'b1111; #1;
    chk("rst_mid/resp_val", 64'(resp_val), 64'(4'b0100));
    rst_n = 1'b0; #1;
    idle_outputs("rst_mid/async");
    chk("rst_mid/grant", 64'(arb_grant_id), 64'(0));
    m_ptr = 0;
    pipe_arb_resp_val = 0; pipe_arb_resp_data = '0; resp_rdy = '0;
    @(negedge clk);
    rst_n = 1'b1;
    req_val = 4'b1111; #1;
    txn("post_rst", 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    n_mis++;
    $display("FAIL timeout observed=running expected=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_rd_req_arb.md
MEM_RD_REQ_ARB -- requirements
Module: mem_rd_req_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of read requesters sharing one masked memory read pipe (2..8).
REQ-002 SHALL have parameter REQ_W, default 512, width of a request header flit.
REQ-003 SHALL have parameter RESP_W, default 512, width of a response flit.
REQ-004 SHALL have derived parameter ID_W = $clog2(NUM_REQ), requester index width.
REQ-005 clk  input  1  sole clock; all state is rising-edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 req_val  input  NUM_REQ  per-requester request valid.
REQ-008 req_data  input  NUM_REQ x REQ_W  per-requester request header.
REQ-009 req_rdy  output  NUM_REQ  per-requester request accept.
REQ-010 req_en_mask  input  NUM_REQ  1 = requester eligible for grant.
REQ-011 arb_pipe_req_val  output  1  request to read pipe valid.
REQ-012 arb_pipe_req_data  output  REQ_W  request to read pipe.
REQ-013 pipe_arb_req_rdy  input  1  read pipe accepts request.
REQ-014 pipe_arb_resp_val  input  1  read pipe response flit valid.
REQ-015 pipe_arb_resp_data  input  RESP_W  response flit.
REQ-016 pipe_arb_resp_last  input  1  final flit of response.
REQ-017 arb_pipe_resp_rdy  output  1  response flit accept.
REQ-018 resp_val  output  NUM_REQ  per-requester response valid.
REQ-019 resp_data  output  RESP_W  response flit, broadcast to all requesters.
REQ-020 resp_last  output  1  final-flit marker, broadcast.
REQ-021 resp_rdy  input  NUM_REQ  per-requester response accept.
REQ-022 arb_busy  output  1  high whenever state is not IDLE.
REQ-023 arb_grant_id  output  ID_W  currently granted requester index.

Function
REQ-024 FSM states SHALL be IDLE, REQ_OUT, RESP_OUT.
REQ-025 IDLE: all req_rdy, resp_val, arb_pipe_req_val, arb_pipe_resp_rdy low; if any (req_val & req_en_mask) bit set, register winner into grant_reg, go REQ_OUT.
REQ-026 Winner SHALL be the first eligible index at or above rr_ptr, wrapping modulo NUM_REQ.
REQ-027 REQ_OUT: arb_pipe_req_val = req_val[grant_reg]; arb_pipe_req_data = req_data[grant_reg]; req_rdy[grant_reg] = pipe_arb_req_rdy; other req_rdy low; on val & rdy go RESP_OUT.
REQ-028 RESP_OUT: resp_val[grant_reg] = pipe_arb_resp_val, other resp_val low; arb_pipe_resp_rdy = resp_rdy[grant_reg]; resp_data/resp_last pass through combinationally.
REQ-029 RESP_OUT: on val & rdy & pipe_arb_resp_last, go IDLE and set rr_ptr = grant_reg + 1, wrapping NUM_REQ-1 to 0.
REQ-030 Grant decision latency SHALL be one cycle: request visible in cycle N drives arb_pipe_req_val in cycle N+1 at earliest.
REQ-031 Exactly one transaction outstanding; arb_pipe_resp_rdy SHALL be low outside RESP_OUT.
REQ-032 req_en_mask SHALL be sampled only in IDLE; deasserting a granted requester's bit mid-transaction SHALL NOT abort it.
REQ-033 req_val deassertion by the granted requester in REQ_OUT is a protocol violation; bench SHALL flag it.
REQ-034 Single-flit response (resp_last with first flit) SHALL return to IDLE after that one handshake.
REQ-035 arb_grant_id SHALL equal grant_reg; arb_busy = (state != IDLE).

Reset
REQ-036 On rst_n low: state = IDLE, grant_reg = 0, rr_ptr = 0; all valid/ready outputs low, arb_busy low, arb_grant_id 0, asynchronously.
REQ-037 Reset mid-transaction SHALL drop the transaction; read pipe is reset in the same domain.

Structure
REQ-038 State enum (arb_state_e) SHALL live in shared package mem_rd_arb_pkg.
REQ-039 Round-robin picker SHALL be a combinational sub-module rr_pick (inputs eligible vector, pointer; outputs winner index, any_valid).

Verification
REQ-040 NUM_REQ=4, req_val=4'b1010, rr_ptr=0 -> grant 1; after its last flit rr_ptr=2, next grant 3.
REQ-041 All four requesting continuously, 3-flit responses -> grant order 0,1,2,3,0; no flit to non-granted resp_val.
REQ-042 pipe_arb_req_rdy held low 5 cycles in REQ_OUT -> req_rdy[grant] low, state holds, data stable.
REQ-043 resp_rdy[grant] toggling 1,0,1 -> arb_pipe_resp_rdy mirrors it; no flit lost or duplicated.
REQ-044 req_en_mask=4'b0111, only requester 3 valid -> stays IDLE; mask cleared for bit 0 mid RESP_OUT of grant 0 -> transaction completes.
REQ-045 rst_n asserted during RESP_OUT -> outputs low immediately, state IDLE, rr_ptr 0.
